// File: rtl/lb_pkg.sv
// ============================================================================
// Module      : lb_pkg
// Description : Shared types and constants for the 3-row line buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lb_pkg;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } lb_state_e;

  localparam int C_DEFAULT_WIDTH = 24;

  // RGB888 field positions inside a pixel word
  localparam int C_R_HI = 23;
  localparam int C_R_LO = 16;
  localparam int C_G_HI = 15;
  localparam int C_G_LO = 8;
  localparam int C_B_HI = 7;
  localparam int C_B_LO = 0;

endpackage

`default_nettype wire

// File: rtl/line_ram.sv
// ============================================================================
// Module      : line_ram
// Description : Simple dual-port line RAM, one write and one synchronous
//               read-first read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_ram
  import lb_pkg::*;
#(
  parameter int WIDTH  = C_DEFAULT_WIDTH,
  parameter int DEPTH  = 480,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // A read to the address being written returns the old word.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/line_buffer_3row.sv
// ============================================================================
// Module      : line_buffer_3row
// Description : Turns a raster RGB stream into three vertically aligned rows
//               (y-2, y-1, y). Optional macro BORDER_REPLICATE_EN emits the
//               first two rows with replicated borders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer_3row
  import lb_pkg::*;
#(
  parameter int WIDTH      = C_DEFAULT_WIDTH,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272,
  parameter int ADDR_W     = $clog2(PIC_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             eol_out
);

  localparam int                ROW_W      = $clog2(PIC_HEIGHT);
  localparam logic [ADDR_W-1:0] C_COL_LAST = ADDR_W'(PIC_WIDTH - 1);
  localparam logic [ROW_W-1:0]  C_ROW_LAST = ROW_W'(PIC_HEIGHT - 1);
`ifdef BORDER_REPLICATE_EN
  localparam logic              C_REPLICATE = 1'b1;
`else
  localparam logic              C_REPLICATE = 1'b0;
`endif

  logic [ADDR_W-1:0] r_col, w_col, w_col_next, r_b_addr;
  logic [ROW_W-1:0]  r_row, w_row, w_row_next;
  lb_state_e         r_state, w_state, w_state_next, r_q_state;
  logic              w_col_wrap, w_out_en;
  logic              r_b_we, r_q_vld, r_eol;
  logic [WIDTH-1:0]  w_ram_a_q, w_ram_b_q, r_din_d;
  logic [WIDTH-1:0]  r_hold1, r_hold2, r_hold3;
  logic [WIDTH-1:0]  w_live1, w_live2, w_live3;

  // sof relocates the current pixel to (0,0) before it is processed
  always_comb begin
    w_col      = sof ? '0 : r_col;
    w_row      = sof ? '0 : r_row;
    w_state    = sof ? FILL0 : r_state;
    w_col_wrap = (w_col == C_COL_LAST);
    w_col_next = w_col_wrap ? '0 : w_col + ADDR_W'(1);
    w_row_next   = w_row;
    w_state_next = w_state;
    if (w_col_wrap) begin
      if (w_row == C_ROW_LAST) begin
        w_row_next   = '0;
        w_state_next = FILL0;
      end else begin
        w_row_next   = w_row + ROW_W'(1);
        w_state_next = (w_state == FILL0) ? FILL1 : RUN;
      end
    end
    w_out_en = C_REPLICATE || (w_state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_state   <= FILL0;
      r_q_state <= FILL0;
      r_b_we    <= 1'b0;
      r_b_addr  <= '0;
      r_q_vld   <= 1'b0;
      r_eol     <= 1'b0;
      r_din_d   <= '0;
      r_hold1   <= '0;
      r_hold2   <= '0;
      r_hold3   <= '0;
    end else begin
      r_q_vld <= valid_in && w_out_en;
      r_eol   <= valid_in && w_out_en && w_col_wrap;
      if (r_q_vld) begin
        r_hold1 <= w_live1;
        r_hold2 <= w_live2;
        r_hold3 <= w_live3;
      end
      if (valid_in) begin
        r_col     <= w_col_next;
        r_row     <= w_row_next;
        r_state   <= w_state_next;
        r_q_state <= w_state;
        r_din_d   <= din;
        r_b_we    <= 1'b1;
        r_b_addr  <= w_col;
      end
    end
  end

  line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram_a (
    .clk  (clk),
    .we   (valid_in),
    .waddr(w_col),
    .wdata(din),
    .re   (valid_in),
    .raddr(w_col),
    .rdata(w_ram_a_q)
  );

  // Line y-1 migrates into RAM_B one cycle after it was read out of RAM_A
  line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram_b (
    .clk  (clk),
    .we   (r_b_we),
    .waddr(r_b_addr),
    .wdata(w_ram_a_q),
    .re   (valid_in),
    .raddr(w_col),
    .rdata(w_ram_b_q)
  );

  always_comb begin
    case (r_q_state)
      RUN: begin
        w_live1 = w_ram_b_q;
        w_live2 = w_ram_a_q;
      end
      FILL1: begin
        w_live1 = w_ram_a_q;
        w_live2 = w_ram_a_q;
      end
      default: begin
        w_live1 = r_din_d;
        w_live2 = r_din_d;
      end
    endcase
    w_live3 = r_din_d;
  end

  // Outputs follow the RAM read registers on a beat and hold otherwise
  assign valid_out = r_q_vld;
  assign eol_out   = r_eol;
  assign dout1     = r_q_vld ? w_live1 : r_hold1;
  assign dout2     = r_q_vld ? w_live2 : r_hold2;
  assign dout3     = r_q_vld ? w_live3 : r_hold3;

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_3row.sv
// ============================================================================
// Module      : tb_line_buffer_3row
// Description : Self-checking bench for line_buffer_3row on a 4x4 picture
//               with pixel value row*16+col.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_buffer_3row;

  localparam int W  = 24;
  localparam int PW = 4;
  localparam int PH = 4;
`ifdef BORDER_REPLICATE_EN
  localparam bit REPL        = 1'b1;
  localparam int FRAME_BEATS = 16;
`else
  localparam bit REPL        = 1'b0;
  localparam int FRAME_BEATS = 8;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         valid_in = 1'b0;
  logic         sof      = 1'b0;
  logic [W-1:0] din      = '0;
  logic         valid_out, eol_out;
  logic [W-1:0] dout1, dout2, dout3;

  typedef struct {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic         eol;
  } exp_t;

  typedef struct {
    logic         vin;
    logic         sof;
    logic [W-1:0] din;
    logic         vout;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic         eol;
  } vec_t;

  exp_t         q[$];
  vec_t         tbl[PH*PW];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           beats   = 0;
  logic         prev_vin = 1'b0;
  logic [W-1:0] img [PH][PW];
  int           m_row = 0;
  int           m_col = 0;

  always #5 clk = ~clk;

  line_buffer_3row #(
    .WIDTH     (W),
    .PIC_WIDTH (PW),
    .PIC_HEIGHT(PH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .sof      (sof),
    .din      (din),
    .valid_out(valid_out),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3),
    .eol_out  (eol_out)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      beats++;
      check("beat_follows_valid_in", W'(prev_vin), W'(1));
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got dout1=%h dout2=%h dout3=%h, expected no beat",
                 dout1, dout2, dout3);
      end else begin
        e = q.pop_front();
        check("dout1", dout1, e.d1);
        check("dout2", dout2, e.d2);
        check("dout3", dout3, e.d3);
        check("eol_out", W'(eol_out), W'(e.eol));
      end
    end
    prev_vin = valid_in;
  end

  // Reference: keeps the current frame's rows and derives the three taps
  task automatic model_push(input logic s, input logic [W-1:0] d);
    exp_t e;
    if (s) begin
      m_row = 0;
      m_col = 0;
    end
    e.d3 = d;
    if (m_row >= 2) begin
      e.d1 = img[m_row-2][m_col];
      e.d2 = img[m_row-1][m_col];
    end else if (m_row == 1) begin
      e.d1 = img[0][m_col];
      e.d2 = img[0][m_col];
    end else begin
      e.d1 = d;
      e.d2 = d;
    end
    e.eol = (m_col == PW - 1);
    if (REPL || m_row >= 2) q.push_back(e);
    img[m_row][m_col] = d;
    if (m_col == PW - 1) begin
      m_col = 0;
      m_row = (m_row == PH - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic send(input logic s, input logic [W-1:0] d);
    @(posedge clk); #1;
    valid_in = 1'b1;
    sof      = s;
    din      = d;
    model_push(s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      sof      = 1'b0;
    end
  endtask

  task automatic send_frame(input logic with_sof, input int gap);
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        send(with_sof && r == 0 && c == 0, W'(r * 16 + c));
        if (gap > 0) idle(gap);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   idx;

    // closed-form expectations for one continuous frame
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        idx = r * PW + c;
        tbl[idx].vin = 1'b1;
        tbl[idx].sof = (idx == 0);
        tbl[idx].din = W'(r * 16 + c);
        tbl[idx].d3  = W'(r * 16 + c);
        if (r >= 2) begin
          tbl[idx].vout = 1'b1;
          tbl[idx].d1   = W'((r - 2) * 16 + c);
          tbl[idx].d2   = W'((r - 1) * 16 + c);
        end else begin
          tbl[idx].vout = REPL;
          tbl[idx].d1   = W'((r == 1) ? c : r * 16 + c);
          tbl[idx].d2   = W'((r == 1) ? c : r * 16 + c);
        end
        tbl[idx].eol = tbl[idx].vout && (c == PW - 1);
      end
    end

    #2 rst_n = 1'b0;
    #1;
    check("reset_valid_out", W'(valid_out), '0);
    check("reset_eol_out", W'(eol_out), '0);
    check("reset_dout1", dout1, '0);
    check("reset_dout2", dout2, '0);
    check("reset_dout3", dout3, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // continuous frame from the vector table
    beats = 0;
    for (int i = 0; i < PH * PW; i++) begin
      @(posedge clk); #1;
      valid_in = tbl[i].vin;
      sof      = tbl[i].sof;
      din      = tbl[i].din;
      if (tbl[i].vout) begin
        e.d1  = tbl[i].d1;
        e.d2  = tbl[i].d2;
        e.d3  = tbl[i].d3;
        e.eol = tbl[i].eol;
        q.push_back(e);
      end
    end
    idle(3);
    check("table_beats", W'(beats), W'(FRAME_BEATS));
    check("idle_valid_out", W'(valid_out), '0);
    check("idle_eol_out", W'(eol_out), '0);
    check("idle_hold_dout1", dout1, W'('h13));
    check("idle_hold_dout2", dout2, W'('h23));
    check("idle_hold_dout3", dout3, W'('h33));

    // every-other-cycle valid_in
    beats = 0;
    send_frame(1'b1, 1);
    idle(2);
    check("gapped_beats", W'(beats), W'(FRAME_BEATS));

    // sof at (row 2, col 2) restarts a fresh frame
    beats = 0;
    for (int i = 0; i < 2 * PW + 2; i++) send(i == 0, W'((i / PW) * 16 + (i % PW)));
    send(1'b1, W'('h00));
    send(1'b0, W'('h01));
    idle(2);
`ifndef BORDER_REPLICATE_EN
    check("sof_fill_hold_dout1", dout1, W'('h01));
    check("sof_fill_hold_dout2", dout2, W'('h11));
    check("sof_fill_hold_dout3", dout3, W'('h21));
`endif
    for (int i = 2; i < PH * PW; i++) send(1'b0, W'((i / PW) * 16 + (i % PW)));
    idle(2);
    check("sof_beats", W'(beats), W'(FRAME_BEATS + (REPL ? 10 : 2)));

    // asynchronous reset in the middle of row 3
    for (int i = 0; i < 3 * PW + 2; i++) send(i == 0, W'((i / PW) * 16 + (i % PW)));
    @(posedge clk); #1;
    valid_in = 1'b0;
    sof      = 1'b0;
    check("pre_reset_valid_out", W'(valid_out), W'(1));
    rst_n = 1'b0;
    #1;
    check("midreset_valid_out", W'(valid_out), '0);
    check("midreset_eol_out", W'(eol_out), '0);
    check("midreset_dout1", dout1, '0);
    check("midreset_dout2", dout2, '0);
    check("midreset_dout3", dout3, '0);
    q.delete();
    idle(2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_row = 0;
    m_col = 0;

    // two back-to-back frames, sof only on the first
    beats = 0;
    send_frame(1'b1, 0);
    send_frame(1'b0, 0);
    idle(3);
    check("b2b_beats", W'(beats), W'(2 * FRAME_BEATS));
    check("scoreboard_drained", W'(q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
